br_pred_perf_monitor: RTL

- Parametrised branch-prediction and pipeline performance monitor for the pipelined CPU.
- Carries per-predictor predictions from fetch through a stall-gated delay line to the resolve stage.
- Compares each prediction against the resolved outcome and keeps saturating counters for total branches, flushes, alignment errors, and per-predictor correct/incorrect counts.
- Exposes the counters through a registered read port, plus a best-predictor indicator. Generalises the ad-hoc testbench counters to N predictors, configurable delay and width, stall-correct counting, and saturation.

---
 rtl/br_pred_perf_monitor.sv | 129 ++++++++++++
 1 files changed

// File: rtl/br_pred_perf_monitor.sv
//------------------------------------------------------------------------------
// Module  : br_pred_perf_monitor
// Brief   : Branch-predictor accuracy and pipeline event counters with a
//           registered read port and best-predictor indicator.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module br_pred_perf_monitor #(
  parameter int NUM_PRED = 3,
  parameter int DELAY    = 2,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                pred_valid_in,
  input  logic [NUM_PRED-1:0] pred_in,
  input  logic                resolve_valid,
  input  logic                br_taken,
  input  logic                flush,
  input  logic                clear,
  input  logic [7:0]          rd_idx,
  output logic [CNT_W-1:0]    rd_data,
  output logic                rd_sat,
  output logic [2:0]          best_pred
);

  localparam int NCNT = 3 + 2 * NUM_PRED;

  logic [DELAY-1:0]    vld_q;
  logic [NUM_PRED-1:0] pred_q [DELAY];
  logic [CNT_W-1:0]    cnt_q  [NCNT];
  logic [NCNT-1:0]     sat_q;
  logic [NCNT-1:0]     cnt_inc;
  logic [CNT_W-1:0]    rd_data_q, rd_data_d;
  logic                rd_sat_q, rd_sat_d;
  logic [2:0]          best_q, best_d;
  logic [CNT_W-1:0]    best_val;
  logic                res_ok;
  logic                d_vld;
  logic [NUM_PRED-1:0] d_pred;

  assign res_ok = resolve_valid & ~stall;
  assign d_vld  = vld_q[DELAY-1];
  assign d_pred = pred_q[DELAY-1];

  // Squashed instructions lose their valid bit as they move past stage 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < DELAY; k++) pred_q[k] <= '0;
    end else if (!stall) begin
      vld_q[0]  <= pred_valid_in;
      pred_q[0] <= pred_in;
      for (int k = 1; k < DELAY; k++) begin
        vld_q[k]  <= vld_q[k-1] & ~flush;
        pred_q[k] <= pred_q[k-1];
      end
    end
  end

  always_comb begin
    cnt_inc    = '0;
    cnt_inc[0] = res_ok;
    cnt_inc[1] = flush & ~stall;
    cnt_inc[2] = res_ok & ~d_vld;
    for (int i = 0; i < NUM_PRED; i++) begin
      cnt_inc[3+2*i] = res_ok & d_vld & (d_pred[i] == br_taken);
      cnt_inc[4+2*i] = res_ok & d_vld & (d_pred[i] != br_taken);
    end
  end

  // Saturating counters; the sat flag is sticky once an increment hits all-ones.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int k = 0; k < NCNT; k++) cnt_q[k] <= '0;
      sat_q <= '0;
    end else begin
      for (int k = 0; k < NCNT; k++) begin
        if (cnt_inc[k]) begin
          if (&cnt_q[k]) sat_q[k] <= 1'b1;
          else           cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    rd_sat_d  = 1'b0;
    for (int k = 0; k < NCNT; k++) begin
      if (rd_idx == 8'(k)) begin
        rd_data_d = cnt_q[k];
        rd_sat_d  = sat_q[k];
      end
    end
  end

  always_comb begin
    best_d   = '0;
    best_val = cnt_q[3];
    for (int i = 1; i < NUM_PRED; i++) begin
      if (cnt_q[3+2*i] > best_val) begin
        best_val = cnt_q[3+2*i];
        best_d   = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
      rd_sat_q  <= 1'b0;
      best_q    <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_sat_q  <= rd_sat_d;
      best_q    <= clear ? 3'd0 : best_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_sat    = rd_sat_q;
  assign best_pred = best_q;

endmodule

`default_nettype wire
